// File: rtl/sparse_pkg.sv
// Shared definitions for the sparse datapath: width helpers and the compactor state encoding.
package sparse_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (longint unsigned v = 1; v < longint'(n); v = v << 1) r++;
    return r;
  endfunction

  // Narrowest count width able to hold 0..bitmask_length inclusive.
  function automatic int unsigned min_index_bits(input int unsigned bitmask_length);
    return clog2(bitmask_length + 1);
  endfunction

  localparam int unsigned DEFAULT_MIN_INDEX_BITWIDTH = min_index_bits(16);

endpackage

// File: rtl/prefix_count_unit.sv
// Combinational inclusive prefix popcount: counts[i] = number of set bits in mask[0..i].
module prefix_count_unit
  import sparse_pkg::*;
#(
  parameter int unsigned BITMASK_LENGTH = 16,
  parameter int unsigned INDEX_BITWIDTH = 5
) (
  input  logic [BITMASK_LENGTH-1:0]                mask,
  output logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] counts
);

  localparam int unsigned BML = BITMASK_LENGTH;
  localparam int unsigned IW  = INDEX_BITWIDTH;

  logic [IW-1:0] acc;

  always_comb begin
    acc    = '0;
    counts = '0;
    for (int unsigned i = 0; i < BML; i++) begin
      acc = acc + IW'(mask[i]);
      counts[i*IW +: IW] = acc;
    end
  end

endmodule

// File: rtl/sparse_value_compactor.sv
// Streaming compactor: packs mask-selected values LSB-first into OUT_LANES-wide beats,
// one or more beats per accepted word, with full back-to-back throughput.
module sparse_value_compactor
  import sparse_pkg::*;
#(
  parameter int unsigned BITMASK_LENGTH = 16,
  parameter int unsigned VALUE_WIDTH    = 8,
  parameter int unsigned OUT_LANES      = 4,
  parameter int unsigned INDEX_BITWIDTH = 5
) (
  input  logic                                  clock,
  input  logic                                  resetn,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [BITMASK_LENGTH-1:0]             in_bitmask,
  input  logic [VALUE_WIDTH*BITMASK_LENGTH-1:0] in_values,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [VALUE_WIDTH*OUT_LANES-1:0]      out_values,
  output logic [INDEX_BITWIDTH-1:0]             out_count,
  output logic                                  out_last
);

  localparam int unsigned BML = BITMASK_LENGTH;
  localparam int unsigned VW  = VALUE_WIDTH;
  localparam int unsigned OL  = OUT_LANES;
  localparam int unsigned IW  = INDEX_BITWIDTH;

  if (INDEX_BITWIDTH < min_index_bits(BITMASK_LENGTH)) begin : g_index_width_check
    $error("INDEX_BITWIDTH too narrow to count BITMASK_LENGTH set bits");
  end
  if (OUT_LANES < 1 || OUT_LANES > BITMASK_LENGTH) begin : g_lane_check
    $error("OUT_LANES must lie in 1..BITMASK_LENGTH");
  end

  state_t                state;
  logic [BML-1:0]        mask_q;
  logic [VW*BML-1:0]     values_q;
  logic [BML*IW-1:0]     prefix_q;
  logic [BML*IW-1:0]     prefix_c;
  logic [IW-1:0]         base_q;

  logic [IW-1:0]         total_c;
  logic [IW-1:0]         remain_c;
  logic [IW:0]           beat_end_c;
  logic                  last_c;
  logic                  out_fire_c;
  logic                  in_fire_c;
  logic [VW*OL-1:0]      lanes_c;

  prefix_count_unit #(
    .BITMASK_LENGTH(BML),
    .INDEX_BITWIDTH(IW)
  ) u_prefix (
    .mask  (in_bitmask),
    .counts(prefix_c)
  );

  // Beat bookkeeping; the end-of-beat sum is one bit wider so it cannot wrap.
  assign total_c    = prefix_q[(BML-1)*IW +: IW];
  assign remain_c   = total_c - base_q;
  assign beat_end_c = {1'b0, base_q} + (IW+1)'(OL);
  assign last_c     = (beat_end_c >= {1'b0, total_c});

  assign out_fire_c = (state == DRAIN) && out_ready;
  assign in_ready   = (state == EMPTY) || (out_fire_c && last_c);
  assign in_fire_c  = in_valid && in_ready;

  // Per-lane one-hot match of rank P[i]-1 against B+j, OR-reduced into the lane.
  always_comb begin
    lanes_c = '0;
    for (int unsigned j = 0; j < OL; j++) begin
      for (int unsigned i = 0; i < BML; i++) begin
        if (mask_q[i] &&
            (((IW+1)'(prefix_q[i*IW +: IW]) - (IW+1)'(1)) == ({1'b0, base_q} + (IW+1)'(j)))) begin
          lanes_c[j*VW +: VW] = lanes_c[j*VW +: VW] | values_q[i*VW +: VW];
        end
      end
    end
  end

  assign out_valid  = (state == DRAIN);
  assign out_values = out_valid ? lanes_c : '0;
  assign out_count  = !out_valid ? '0 : ((remain_c > IW'(OL)) ? IW'(OL) : remain_c);
  assign out_last   = out_valid && last_c;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= EMPTY;
      mask_q   <= '0;
      values_q <= '0;
      prefix_q <= '0;
      base_q   <= '0;
    end else if (in_fire_c) begin
      state    <= DRAIN;
      mask_q   <= in_bitmask;
      values_q <= in_values;
      prefix_q <= prefix_c;
      base_q   <= '0;
    end else if (out_fire_c) begin
      if (last_c) begin
        state  <= EMPTY;
        base_q <= '0;
      end else begin
        base_q <= base_q + IW'(OL);
      end
    end
  end

endmodule

// File: tb/tb_sparse_value_compactor.sv
// Scoreboard bench for sparse_value_compactor: a queue-based reference model predicts every beat.
module tb_sparse_value_compactor;

  localparam int BML = 16;
  localparam int VW  = 8;
  localparam int OL  = 4;
  localparam int IW  = 5;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BML-1:0]    in_bitmask = '0;
  logic [VW*BML-1:0] in_values = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [VW*OL-1:0]  out_values;
  logic [IW-1:0]     out_count;
  logic              out_last;

  sparse_value_compactor #(
    .BITMASK_LENGTH(BML),
    .VALUE_WIDTH   (VW),
    .OUT_LANES     (OL),
    .INDEX_BITWIDTH(IW)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bitmask(in_bitmask),
    .in_values (in_values),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_values(out_values),
    .out_count (out_count),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [VW*OL-1:0] vals;
    int               cnt;
    bit               last;
  } beat_t;

  beat_t sb[$];
  int tests = 0;
  int fails = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: collect selected values in index order, then chop into OL-sized beats.
  task automatic push_word(input logic [BML-1:0] m, input logic [VW*BML-1:0] v);
    logic [VW-1:0] sel[$];
    beat_t b;
    int nb;
    for (int i = 0; i < BML; i++) if (m[i]) sel.push_back(v[i*VW +: VW]);
    nb = (sel.size() + OL - 1) / OL;
    if (nb == 0) nb = 1;
    for (int k = 0; k < nb; k++) begin
      b.vals = '0;
      b.cnt  = 0;
      for (int j = 0; j < OL; j++) begin
        if (k*OL + j < sel.size()) begin
          b.vals[j*VW +: VW] = sel[k*OL + j];
          b.cnt++;
        end
      end
      b.last = (k == nb - 1);
      sb.push_back(b);
    end
  endtask

  always @(negedge clock) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: samples mid-cycle, after drivers have settled.
  bit prev_accept = 0;
  bit prev_stall  = 0;
  logic [VW*OL+IW+1:0] prev_bundle;
  always @(negedge clock) begin
    bit exp_ir;
    beat_t e;
    #2;
    if (!resetn) begin
      prev_accept = 0;
      prev_stall  = 0;
    end else begin
      exp_ir = !out_valid || (out_ready && sb.size() > 0 && sb[0].last);
      chk("in_ready", 128'(in_ready), 128'(exp_ir));
      if (prev_accept) chk("first_beat_latency", 128'(out_valid), 128'(1));
      if (prev_stall) chk("stall_hold", 128'({out_valid, out_values, out_count, out_last}), 128'(prev_bundle));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 128'(out_count), 128'(0) + 128'(1) << 100);
        end else begin
          e = sb.pop_front();
          chk("out_values", 128'(out_values), 128'(e.vals));
          chk("out_count", 128'(out_count), 128'(e.cnt));
          chk("out_last", 128'(out_last), 128'(e.last));
        end
      end
      if (in_valid && in_ready) push_word(in_bitmask, in_values);
      prev_accept = in_valid && in_ready;
      prev_stall  = out_valid && !out_ready;
      prev_bundle = {out_valid, out_values, out_count, out_last};
    end
  end

  task automatic send_word(input logic [BML-1:0] m, input logic [VW*BML-1:0] v);
    int n;
    n = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_bitmask = m;
    in_values = v;
    #3;
    while (!in_ready && n < 500) begin
      @(negedge clock);
      #3;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 128'(0), 128'(1));
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    #4;
    chk("drain_timeout", 128'(sb.size()), 128'(0));
  endtask

  function automatic logic [VW*BML-1:0] ramp_values();
    logic [VW*BML-1:0] v;
    for (int i = 0; i < BML; i++) v[i*VW +: VW] = VW'(i);
    return v;
  endfunction

  function automatic logic [VW*BML-1:0] rand_values();
    logic [VW*BML-1:0] v;
    for (int i = 0; i < BML; i++) v[i*VW +: VW] = VW'($urandom);
    return v;
  endfunction

  initial begin
    logic [VW*BML-1:0] v;
    logic [BML-1:0] m;
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_count", 128'(out_count), 128'(0));
    chk("reset_out_last", 128'(out_last), 128'(0));
    chk("reset_out_values", 128'(out_values), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    ready_mode = 0;
    send_word(16'h0000, rand_values());
    wait_drain();
    send_word(16'hFFFF, ramp_values());
    wait_drain();
    v = '0;
    v[0 +: VW] = 8'h0A;
    v[15*VW +: VW] = 8'h0B;
    send_word(16'h8001, v);
    wait_drain();

    // Stall with a held beat, then release.
    ready_mode = 2;
    send_word(16'h00FF, rand_values());
    repeat (6) @(negedge clock);
    #4;
    chk("stall_valid", 128'(out_valid), 128'(1));
    chk("stall_in_ready", 128'(in_ready), 128'(0));
    ready_mode = 0;
    wait_drain();

    // Back-to-back words with no bubble.
    send_word(16'h000F, ramp_values());
    send_word(16'h00F0, ramp_values());
    wait_drain();

    // Reset during the second beat discards the word.
    send_word(16'hFFFF, ramp_values());
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("midreset_out_valid", 128'(out_valid), 128'(0));
    chk("midreset_out_count", 128'(out_count), 128'(0));
    chk("midreset_in_ready", 128'(in_ready), 128'(1));
    sb.delete();
    @(negedge clock);
    resetn = 1'b1;
    send_word(16'h0F0F, ramp_values());
    wait_drain();

    // Randomized traffic with random back-pressure and input gaps.
    ready_mode = 1;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: m = BML'($urandom) & BML'($urandom);
        1: m = BML'($urandom);
        2: m = BML'($urandom) | BML'($urandom);
        default: m = ($urandom_range(0, 1) != 0) ? '0 : '1;
      endcase
      send_word(m, rand_values());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    ready_mode = 0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
